counter_run_controller: RTL and testbench

//  Run/pause/stop sequencer for the 4-bit up/down counter datapath on the FPGA board.

---
 rtl/counter_run_controller.sv | 130 +++++++++++++
 tb/tb_counter_run_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/counter_run_controller.sv
// Run/pause/stop sequencer for a WIDTH-bit up/down counter: prescaled tick, load/enable/direction strobes.
// Optional AUTO_RELOAD_EN: a terminal tick reloads load_val and pulses done instead of entering DONE.
module counter_run_controller #(
  parameter int DIV   = 50_000_000,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             tick,
  output logic [1:0]       state,
  output logic             done
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             cnt_load_d, cnt_en_d, cnt_up_d, tick_d, done_d;
  logic [WIDTH-1:0] cnt_load_val_d;
  logic             terminal;
  logic             reload_pulse;

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
      cnt_en       <= 1'b0;
      cnt_up       <= 1'b1;
      tick         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_load     <= cnt_load_d;
      cnt_load_val <= cnt_load_val_d;
      cnt_en       <= cnt_en_d;
      cnt_up       <= cnt_up_d;
      tick         <= tick_d;
      done         <= done_d;
    end
  end

  // Every output is the registered image of the value computed here.
  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    cnt_load_d     = 1'b0;
    cnt_load_val_d = cnt_load_val;
    cnt_en_d       = 1'b0;
    cnt_up_d       = cnt_up;
    tick_d         = 1'b0;
    terminal       = 1'b0;
    reload_pulse   = 1'b0;

    if (stop) begin
      state_d = IDLE;
      presc_d = '0;
    end else if (start) begin
      state_d        = RUN;
      presc_d        = '0;
      cnt_load_d     = 1'b1;
      cnt_load_val_d = load_val;
    end else begin
      case (state_q)
        IDLE, DONE: presc_d = '0;
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            // Hold modes (sel[1]=1) tick without ever counting or terminating.
            if (!sel[1]) begin
              terminal = sel[0] ? (count_in == '0) : (count_in == limit);
              if (terminal) begin
`ifdef AUTO_RELOAD_EN
                cnt_load_d     = 1'b1;
                cnt_load_val_d = load_val;
                reload_pulse   = 1'b1;
`else
                state_d = DONE;
                presc_d = '0;
`endif
              end else begin
                cnt_en_d = 1'b1;
                cnt_up_d = ~sel[0];
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef AUTO_RELOAD_EN
    done_d = reload_pulse;
`else
    done_d = (state_d == DONE);
`endif
  end

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed bench for counter_run_controller (DIV=4, WIDTH=4) with a behavioural counter on count_in.
module tb_counter_run_controller;

  localparam int DIV   = 4;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [1:0]       sel = 2'b00;
  logic [WIDTH-1:0] load_val = '0, limit = '0, count = '0;
  logic             cnt_load, cnt_en, cnt_up, tick, done;
  logic [WIDTH-1:0] cnt_load_val;
  logic [1:0]       state;

  int n_tests = 0;
  int n_fail  = 0;
  int ticks, ens, loads, overlap = 0;
  logic             seq_on = 1'b0;
  logic [WIDTH-1:0] last_count = '0;
  logic [WIDTH-1:0] exp_q[$];

  counter_run_controller #(.DIV(DIV), .WIDTH(WIDTH)) dut (
    .clk(clk), .Reset(rst), .start(start), .pause(pause), .stop(stop),
    .sel(sel), .load_val(load_val), .limit(limit), .count_in(count),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en),
    .cnt_up(cnt_up), .tick(tick), .state(state), .done(done)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // counter datapath model driven by the controller strobes
  always @(posedge clk) begin
    if (rst)           count <= '0;
    else if (cnt_load) count <= cnt_load_val;
    else if (cnt_en)   count <= cnt_up ? count + 4'd1 : count - 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; outputs sampled 1 ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
    if (cnt_en && cnt_load) overlap++;
    if (seq_on && count !== last_count) begin
      if (exp_q.size() == 0) chk("seq_extra", {28'd0, count}, 32'hFFFF_FFFF);
      else chk("seq_value", {28'd0, count}, {28'd0, exp_q.pop_front()});
      last_count = count;
    end
  endtask

  task automatic run(input int n);
    ticks = 0; ens = 0; loads = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      ticks += int'(tick);
      ens   += int'(cnt_en);
      loads += int'(cnt_load);
    end
  endtask

  task automatic do_start(input logic [1:0] s, input logic [3:0] lv, input logic [3:0] lim);
    sel = s; load_val = lv; limit = lim; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    // reset
    run(2);
    rst = 1'b0;
    chk("rst_state", state, 2'b00);
    chk("rst_cnt_up", cnt_up, 1'b1);
    chk("rst_strobes", {cnt_load, cnt_en, tick, done}, 4'b0000);
    chk("rst_load_val", cnt_load_val, 4'd0);

    // 1: up count 3..6 then DONE
    last_count = count; seq_on = 1'b1;
    exp_q.push_back(4'd3); exp_q.push_back(4'd4); exp_q.push_back(4'd5); exp_q.push_back(4'd6);
    do_start(2'b00, 4'd3, 4'd6);
    chk("t1_load", {cnt_load, cnt_load_val}, {1'b1, 4'd3});
    chk("t1_state_run", state, 2'b01);
    run(3);
    chk("t1_no_early_tick", ticks + ens, 0);
    cyc();
    chk("t1_first_en", {tick, cnt_en, cnt_up}, 3'b111);
    run(11);
    chk("t1_mid_ens", ens, 2);
    chk("t1_count6", count, 4'd6);
    cyc();
    chk("t1_done_state", state, 2'b11);
    chk("t1_done_flags", {done, tick, cnt_en}, 3'b110);
    run(8);
    chk("t1_done_hold", {state, done, 3'(ticks), 3'(ens)}, {2'b11, 1'b1, 3'd0, 3'd0});
    seq_on = 1'b0;
    chk("t1_seq_drained", exp_q.size(), 0);

    // 2: down count 2,1,0 then DONE
    do_start(2'b01, 4'd2, 4'd9);
    chk("t2_load", {cnt_load, cnt_load_val, done}, {1'b1, 4'd2, 1'b0});
    run(3);
    cyc();
    chk("t2_first_en_down", {tick, cnt_en, cnt_up}, 3'b110);
    run(7);
    chk("t2_mid", {3'(ens), count}, {3'd1, 4'd0});
    cyc();
    chk("t2_done", {state, done, tick, cnt_en}, {2'b11, 1'b1, 1'b1, 1'b0});

    // 3: pause mid-prescale
    do_start(2'b00, 4'd0, 4'd15);
    run(2);
    pause = 1'b1;
    run(10);
    chk("t3_paused", {state, 3'(ticks), 3'(ens)}, {2'b10, 3'd0, 3'd0});
    pause = 1'b0;
    cyc();
    chk("t3_resume", {state, tick}, {2'b01, 1'b0});
    cyc();
    chk("t3_no_tick_yet", tick, 1'b0);
    cyc();
    chk("t3_remaining_tick", {tick, cnt_en}, 2'b11);

    // 4: stop+start together, then reset mid-run
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    chk("t4_stop_wins", {state, cnt_load, cnt_en, tick}, {2'b00, 3'b000});
    do_start(2'b01, 4'd5, 4'd0);
    run(3);
    cyc();
    chk("t4_down_en", {cnt_en, cnt_up}, 2'b10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t4_reset_all", {state, cnt_load, cnt_load_val, cnt_en, cnt_up, tick, done},
        {2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});

    // 5: hold mode ticks without counting, then resume up
    do_start(2'b10, 4'd7, 4'd9);
    run(12);
    chk("t5_hold", {state, 3'(ticks), 3'(ens), count}, {2'b01, 3'd3, 3'd0, 4'd7});
    sel = 2'b00;
    run(4);
    chk("t5_resume", {3'(ticks), 3'(ens), cnt_up}, {3'd1, 3'd1, 1'b1});
    cyc();
    chk("t5_count8", count, 4'd8);

    // 6: up wrap 14,15,0,1 with limit below load_val
    last_count = count; seq_on = 1'b1;
    exp_q.push_back(4'd14); exp_q.push_back(4'd15); exp_q.push_back(4'd0); exp_q.push_back(4'd1);
    do_start(2'b00, 4'd14, 4'd1);
    run(15);
    chk("t6_ens", ens, 3);
    cyc();
`ifdef AUTO_RELOAD_EN
    exp_q.push_back(4'd14);
    chk("t6_reload", {state, cnt_load, cnt_load_val, done, cnt_en, tick},
        {2'b01, 1'b1, 4'd14, 1'b1, 1'b0, 1'b1});
    cyc();
    chk("t6_after_reload", {state, done, cnt_load, count}, {2'b01, 1'b0, 1'b0, 4'd14});
`else
    chk("t6_done", {state, done, cnt_en, cnt_load}, {2'b11, 1'b1, 1'b0, 1'b0});
    cyc();
    chk("t6_done_hold", {state, done, count}, {2'b11, 1'b1, 4'd1});
`endif
    seq_on = 1'b0;
    chk("t6_seq_drained", exp_q.size(), 0);
    chk("no_en_load_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
